// File: rtl/kf_state_estimator_if.sv
// Sample/estimate bus of the scalar Kalman state estimator.
//
// Signals:
//   z         measurement sample, Q4.28 signed          (master -> slave)
//   vc        controller output applied this sample     (master -> slave)
//   z_valid   z/vc valid                                (master -> slave)
//   z_ready   estimator idle, can accept a sample       (slave -> master)
//   xf        filtered state estimate, held             (slave -> master)
//   xf_valid  one-cycle pulse: xf updated               (slave -> master)
//   sat_flag  sticky arithmetic saturation indicator    (slave -> master)
//
// Modports: master = sample producer / estimate consumer, slave = estimator.

interface kf_state_estimator_if #(
    parameter int unsigned N = 32
) ();

    logic signed [N-1:0] z;
    logic signed [N-1:0] vc;
    logic                z_valid;
    logic                z_ready;
    logic signed [N-1:0] xf;
    logic                xf_valid;
    logic                sat_flag;

    modport master (
        output z,
        output vc,
        output z_valid,
        input  z_ready,
        input  xf,
        input  xf_valid,
        input  sat_flag
    );

    modport slave (
        input  z,
        input  vc,
        input  z_valid,
        output z_ready,
        output xf,
        output xf_valid,
        output sat_flag
    );

endinterface

// File: rtl/kf_state_estimator.sv
// Scalar fixed-gain (steady-state) Kalman estimator.
//
// Per accepted sample:
//   xpred = A*xf + B*vc;  e = z - xpred;  xf <= xpred + K*e
// A single shared Q4.28 multiplier and a single shared adder/subtractor are
// sequenced by an FSM: IDLE -> MUL_A -> MUL_B -> INNOV -> MUL_K -> UPD -> IDLE.
// xf and xf_valid update on the 5th rising edge after the accepting edge.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   kf_state_estimator_if.slave (z, vc, z_valid, z_ready, xf, xf_valid, sat_flag)
//
// Configuration:
//   KF_SAT_EN defined   : multiply and add/sub results saturate on overflow and
//                         set the sticky sat_flag.
//   KF_SAT_EN undefined : results wrap modulo 2^N, sat_flag is tied to 0.

module kf_state_estimator #(
    parameter int unsigned         N = 32,
    parameter int unsigned         Q = 28,
    parameter logic signed [N-1:0] A = 32'sh1000_0000,
    parameter logic signed [N-1:0] B = 32'sh0000_0000,
    parameter logic signed [N-1:0] K = 32'sh0800_0000
) (
    input logic                 clk,
    input logic                 rst,
    kf_state_estimator_if.slave bus
);

    // Top bit of the product slice that forms the Q4.28 result.
    localparam int unsigned Hi = N - 1 + Q;

    localparam logic signed [N-1:0] SatMax = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SatMin = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StMulA,
        StMulB,
        StInnov,
        StMulK,
        StUpd
    } state_e;

    state_e state_q, state_d;

    logic signed [N-1:0] z_q, vc_q;
    logic signed [N-1:0] ax_q, xpred_q, e_q, ke_q, xf_q;
    logic                xf_valid_q;
    logic                accept;

    // Shared multiplier
    logic signed [N-1:0]   mul_a, mul_b;
    logic                  mul_en;
    logic signed [2*N-1:0] product;
    logic signed [N-1:0]   mul_raw, mul_res;

    // Shared adder/subtractor
    logic signed [N-1:0] add_a, add_b, add_b_eff, add_sum, add_res;
    logic                add_sub;
    logic                add_en;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign accept = bus.z_valid && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.z_valid) state_d = StMulA;
            StMulA:  state_d = StMulB;
            StMulB:  state_d = StInnov;
            StInnov: state_d = StMulK;
            StMulK:  state_d = StUpd;
            StUpd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_en = 1'b0;
        unique case (state_q)
            StMulA: begin
                mul_a  = A;
                mul_b  = xf_q;
                mul_en = 1'b1;
            end
            StMulB: begin
                mul_a  = B;
                mul_b  = vc_q;
                mul_en = 1'b1;
            end
            StMulK: begin
                mul_a  = K;
                mul_b  = e_q;
                mul_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Kept separate from the multiplier operand mux: in MUL_B the adder
    // consumes the multiplier result in the same cycle.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        add_en  = 1'b0;
        unique case (state_q)
            StMulB: begin
                add_a  = ax_q;
                add_b  = mul_res;
                add_en = 1'b1;
            end
            StInnov: begin
                add_a   = z_q;
                add_b   = xpred_q;
                add_sub = 1'b1;
                add_en  = 1'b1;
            end
            StUpd: begin
                add_a  = xpred_q;
                add_b  = ke_q;
                add_en = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    assign product = $signed({{N{mul_a[N-1]}}, mul_a}) * $signed({{N{mul_b[N-1]}}, mul_b});
    // Dropping the low Q bits of a two's-complement value floors toward -inf.
    assign mul_raw = product[Hi:Q];

    // Subtraction as a + ~b + 1, so one overflow rule covers both operations.
    assign add_b_eff = add_sub ? ~add_b : add_b;
    assign add_sum   = add_a + add_b_eff + {{(N-1){1'b0}}, add_sub};

`ifdef KF_SAT_EN
    logic mul_ovf, add_ovf, sat_hit, sat_q;
    logic unused_product;

    // Bits above the result's sign bit must all replicate it.
    assign mul_ovf = !((&product[2*N-1:Hi]) || !(|product[2*N-1:Hi]));
    assign mul_res = mul_ovf ? (product[2*N-1] ? SatMin : SatMax) : mul_raw;

    assign add_ovf = (add_a[N-1] == add_b_eff[N-1]) && (add_sum[N-1] != add_a[N-1]);
    assign add_res = add_ovf ? (add_a[N-1] ? SatMin : SatMax) : add_sum;

    assign sat_hit = (mul_en && mul_ovf) || (add_en && add_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (sat_hit) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.sat_flag   = sat_q;
    assign unused_product = ^product[Q-1:0];
`else
    logic unused_wrap;

    assign mul_res      = mul_raw;
    assign add_res      = add_sum;
    assign bus.sat_flag = 1'b0;
    assign unused_wrap  = ^{product[2*N-1:Hi+1], product[Q-1:0], mul_en, add_en};
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            z_q        <= '0;
            vc_q       <= '0;
            ax_q       <= '0;
            xpred_q    <= '0;
            e_q        <= '0;
            ke_q       <= '0;
            xf_q       <= '0;
            xf_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            xf_valid_q <= (state_q == StUpd);
            if (accept) begin
                z_q  <= bus.z;
                vc_q <= bus.vc;
            end
            case (state_q)
                StMulA:  ax_q    <= mul_res;
                StMulB:  xpred_q <= add_res;
                StInnov: e_q     <= add_res;
                StMulK:  ke_q    <= mul_res;
                StUpd:   xf_q    <= add_res;
                default: ;
            endcase
        end
    end

    assign bus.z_ready  = (state_q == StIdle);
    assign bus.xf       = xf_q;
    assign bus.xf_valid = xf_valid_q;

endmodule
